// File: rtl/wb_copy_master.sv
// Wishbone block-copy master: word-at-a-time read-then-write engine with a
// single-word holding buffer and a per-access ack timeout.
module wb_copy_master #(
  parameter int LEN_W   = 14,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [18:0]      src_adr,
  input  logic [18:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [18:0]      wb_adr_o,
  output logic [15:0]      wb_dat_o,
  input  logic [15:0]      wb_dat_i,
  output logic             wb_we_o,
  output logic             wb_tga_o,
  output logic [1:0]       wb_sel_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  input  logic             wb_ack_i
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [18:0]      src_q, src_d, dst_q, dst_d, adr_q, adr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [15:0]      dat_q, dat_d;
  logic             err_q, err_d, done_q, done_d, busy_q, busy_d;
  logic             cyc_q, cyc_d, we_q, we_d;
  logic             expire_s;

  // The access has waited its last allowed cycle without an ack.
  assign expire_s = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // Next-state logic; bus outputs are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_adr;
          dst_d   = dst_adr;
          cnt_d   = len;
          err_d   = 1'b0;
          state_d = (len != '0) ? S_RD : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (wb_ack_i) begin
          dat_d   = wb_dat_i;
          state_d = S_WR;
        end else if (expire_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        if (wb_ack_i) begin
          src_d   = src_q + 19'd1;
          dst_d   = dst_q + 19'd1;
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_RD;
        end else if (expire_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Every RD->WR->RD hop is a state change, so the wait count restarts per access.
    if ((state_d == state_q) && ((state_q == S_RD) || (state_q == S_WR))) begin
      wait_d = wait_q + TW'(1);
    end else begin
      wait_d = '0;
    end

    cyc_d  = (state_d == S_RD) || (state_d == S_WR);
    we_d   = (state_d == S_WR);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_RD:    adr_d = src_d;
      S_WR:    adr_d = dst_d;
      default: adr_d = adr_q;
    endcase
  end

  // State and output registers; reset drops cyc/stb without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      src_q   <= 19'd0;
      dst_q   <= 19'd0;
      adr_q   <= 19'd0;
      cnt_q   <= '0;
      wait_q  <= '0;
      dat_q   <= 16'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_stb_o = cyc_q;
  assign wb_cyc_o = cyc_q;
  assign wb_tga_o = 1'b0;
  assign wb_sel_o = 2'b11;

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master: ROM/SRAM slave model, per-cycle bus trace
// model built from the copy rules, and hand-computed latency/data checks.
module tb_wb_copy_master;
  localparam int LEN_W = 14;
  localparam int TO    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [18:0]      src_adr = 19'd0;
  logic [18:0]      dst_adr = 19'd0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err;
  logic [18:0]      wb_adr_o;
  logic [15:0]      wb_dat_o, wb_dat_i;
  logic             wb_we_o, wb_tga_o, wb_stb_o, wb_cyc_o, wb_ack_i;
  logic [1:0]       wb_sel_o;

  wb_copy_master #(.LEN_W(LEN_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
    .len(len), .busy(busy), .done(done), .err(err), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_tga_o(wb_tga_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reads come from the ROM image, writes land in the RAM image.
  logic [15:0] rom [0:524287];
  logic [15:0] ram [0:524287];
  int  waits = 0;
  bit  wr_nack = 1'b0;
  int  wcnt = 0;
  int  wr_count = 0;

  assign wb_dat_i = rom[wb_adr_o];
  assign wb_ack_i = wb_cyc_o && wb_stb_o && (wcnt == waits) && !(wb_we_o && wr_nack);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (wb_ack_i) begin
        if (wb_we_o) begin
          ram[wb_adr_o] <= wb_dat_o;
          wr_count <= wr_count + 1;
        end
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  typedef struct {
    bit        cyc;
    bit        we;
    bit [18:0] adr;
    bit [15:0] dat;
    bit        done;
    bit        busy;
    bit        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;

  task automatic push(input bit c, input bit w, input logic [18:0] a, input logic [15:0] d,
                      input bit dn, input bit b, input bit e);
    exp_t x;
    x.cyc = c; x.we = w; x.adr = a; x.dat = d; x.done = dn; x.busy = b; x.err = e;
    exp_q.push_back(x);
  endtask

  // Expected per-cycle bus trace: each access lasts waits+1 cycles, then one done cycle.
  task automatic build_trace(input logic [18:0] s, input logic [18:0] d, input int n,
                             input int w, input bit nk);
    logic [18:0] sa = s;
    logic [18:0] da = d;
    logic [15:0] word;
    bit e = 1'b0;
    for (int i = 0; i < n && !e; i++) begin
      word = rom[sa];
      for (int k = 0; k <= w; k++) push(1'b1, 1'b0, sa, 16'h0000, 1'b0, 1'b1, 1'b0);
      if (nk) begin
        for (int k = 0; k < TO; k++) push(1'b1, 1'b1, da, word, 1'b0, 1'b1, 1'b0);
        e = 1'b1;
      end else begin
        for (int k = 0; k <= w; k++) push(1'b1, 1'b1, da, word, 1'b0, 1'b1, 1'b0);
      end
      sa = sa + 19'd1;
      da = da + 19'd1;
    end
    push(1'b0, 1'b0, 19'd0, 16'h0000, 1'b1, 1'b1, e);
    push(1'b0, 1'b0, 19'd0, 16'h0000, 1'b0, 1'b0, e);
  endtask

  // Per-cycle comparison against the trace model.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      chk("cyc", wb_cyc_o, cur_e.cyc);
      chk("stb", wb_stb_o, cur_e.cyc);
      chk("we", wb_we_o, cur_e.we);
      if (cur_e.cyc) chk("adr", wb_adr_o, cur_e.adr);
      if (cur_e.we) chk("dat_o", wb_dat_o, cur_e.dat);
      chk("done", done, cur_e.done);
      chk("busy", busy, cur_e.busy);
      chk("err", err, cur_e.err);
    end
  end

  task automatic run_copy(input logic [18:0] s, input logic [18:0] d, input int n,
                          input int w, input bit nk, output int lat);
    bit got = 1'b0;
    @(negedge clk);
    waits = w; wr_nack = nk;
    src_adr = s; dst_adr = d; len = n[LEN_W-1:0]; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    build_trace(s, d, n, w, nk);
    lat = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1'b1);
    @(posedge clk);
    @(posedge clk);
    chk("trace_drained", exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    int wc0;
    bit seen;
    rom[19'h7E000] = 16'hA1A1; rom[19'h7E001] = 16'hA2A2;
    rom[19'h7E002] = 16'hA3A3; rom[19'h7E003] = 16'hA4A4;
    rom[19'h00100] = 16'h1234; rom[19'h00101] = 16'h5678;
    rom[19'h7FFFF] = 16'hBEEF; rom[19'h00000] = 16'hCAFE;
    rom[19'h00200] = 16'h1111;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_adr", wb_adr_o, 19'd0);
    chk("rst_dat", wb_dat_o, 16'd0);
    chk("tga", wb_tga_o, 1'b0);
    chk("sel", wb_sel_o, 2'b11);
    @(negedge clk) rst = 1'b1;

    // Zero-wait 4-word shadow copy out of the top of ROM.
    wc0 = wr_count;
    run_copy(19'h7E000, 19'h01000, 4, 0, 1'b0, lat);
    chk("t1_latency", lat, 9);
    chk("t1_writes", wr_count - wc0, 4);
    chk("t1_ram0", ram[19'h01000], 16'hA1A1);
    chk("t1_ram1", ram[19'h01001], 16'hA2A2);
    chk("t1_ram2", ram[19'h01002], 16'hA3A3);
    chk("t1_ram3", ram[19'h01003], 16'hA4A4);
    chk("t1_err", err, 1'b0);

    // Three wait states per access.
    run_copy(19'h00100, 19'h02000, 2, 3, 1'b0, lat);
    chk("t2_latency", lat, 17);
    chk("t2_ram0", ram[19'h02000], 16'h1234);
    chk("t2_ram1", ram[19'h02001], 16'h5678);

    // Zero-length copy: no bus activity.
    wc0 = wr_count;
    run_copy(19'h00100, 19'h02100, 0, 0, 1'b0, lat);
    chk("t3_latency", lat, 1);
    chk("t3_writes", wr_count - wc0, 0);

    // Source address wraps from 0x7FFFF to 0x00000.
    run_copy(19'h7FFFF, 19'h03000, 2, 0, 1'b0, lat);
    chk("t4_latency", lat, 5);
    chk("t4_ram0", ram[19'h03000], 16'hBEEF);
    chk("t4_ram1", ram[19'h03001], 16'hCAFE);

    // Write never acked: abort after TO wait cycles.
    wc0 = wr_count;
    run_copy(19'h00200, 19'h04000, 3, 0, 1'b1, lat);
    chk("t5_latency", lat, 1 + TO + 1);
    chk("t5_writes", wr_count - wc0, 0);
    chk("t5_err", err, 1'b1);

    // Next start clears the sticky error.
    run_copy(19'h00200, 19'h05000, 1, 0, 1'b0, lat);
    chk("t6_latency", lat, 3);
    chk("t6_err", err, 1'b0);
    chk("t6_ram0", ram[19'h05000], 16'h1111);

    // Asynchronous reset in the middle of a write access.
    @(negedge clk);
    waits = 3; wr_nack = 1'b0;
    src_adr = 19'h00100; dst_adr = 19'h06000; len = LEN_W'(2); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (wb_we_o && wb_stb_o) seen = 1'b1;
    end
    chk("t7_in_wr", seen, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t7_async_cyc", wb_cyc_o, 1'b0);
    chk("t7_async_stb", wb_stb_o, 1'b0);
    chk("t7_async_we", wb_we_o, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("t7_idle_busy", busy, 1'b0);
    chk("t7_idle_cyc", wb_cyc_o, 1'b0);
    @(negedge clk);
    chk("t7_idle_busy2", busy, 1'b0);
    chk("t7_idle_done", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
